// File: rtl/superposition_pkg.sv
// -----------------------------------------------------------------------------
// superposition_pkg
// Shared definitions for the superposition controller:
//   - state_e      : controller sequencing states
//   - DEF_*        : default BW / NIN / TO_CYCLES parameter values
//   - word_at()    : extract word idx of width bw from a packed word vector
// The optional watchdog is enabled by defining SUPERPOS_TIMEOUT_EN.
// -----------------------------------------------------------------------------
package superposition_pkg;

  localparam int DEF_BW        = 16;
  localparam int DEF_NIN       = 2;
  localparam int DEF_TO_CYCLES = 255;

  // Upper bounds used to size the generic word extractor.
  localparam int MAX_BW  = 64;
  localparam int MAX_NIN = 8;
  localparam int PK_W    = MAX_BW * MAX_NIN;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    I_ARM = 3'd1,
    I_RUN = 3'd2,
    O_ARM = 3'd3,
    O_RUN = 3'd4,
    DONE  = 3'd5
  } state_e;

  // Callers zero-extend their packed vector to PK_W and truncate the result
  // to their own word width with a cast.
  function automatic logic [MAX_BW-1:0] word_at(input logic [PK_W-1:0] vec,
                                                input int bw,
                                                input int idx);
    return MAX_BW'(vec >> (idx * bw));
  endfunction

endpackage

// File: rtl/op_handshake_init.sv
// -----------------------------------------------------------------------------
// op_handshake_init
// Initiator side of one ST/RD/RES handshake toward a single callee.
// A launch raises the callee ST and holds it until the callee RD is seen low
// (ack). The first RD high after the ack is the completion; the callee RES is
// captured on that edge. An RD high before the ack is never a completion.
//
// Ports:
//   CLK, RST     clock, synchronous active-high reset
//   launch_i     one-cycle request to start the callee (caller checks RD==1)
//   abort_i      drop the strobe and forget any run in progress
//   clr_i        zero the captured result
//   rd_i, res_i  callee ready / result
//   st_o         callee start strobe
//   done_o       run complete: sticky flag OR completion on this edge
//   res_o        captured callee result
// -----------------------------------------------------------------------------
module op_handshake_init
  import superposition_pkg::*;
#(
  parameter int BW = DEF_BW
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          launch_i,
  input  logic          abort_i,
  input  logic          clr_i,
  input  logic          rd_i,
  input  logic [BW-1:0] res_i,
  output logic          st_o,
  output logic          done_o,
  output logic [BW-1:0] res_o
);

  logic          st_q;
  logic          busy_q;
  logic          ack_q;
  logic          done_q;
  logic [BW-1:0] res_q;
  logic          done_set;

  // Completion happens on the edge where RD is high after the ack was seen.
  assign done_set = busy_q & ack_q & rd_i;

  always_ff @(posedge CLK) begin
    if (RST) begin
      st_q   <= 1'b0;
      busy_q <= 1'b0;
      ack_q  <= 1'b0;
      done_q <= 1'b0;
      res_q  <= '0;
    end else begin
      if (abort_i) begin
        st_q   <= 1'b0;
        busy_q <= 1'b0;
        ack_q  <= 1'b0;
        done_q <= 1'b0;
      end else if (launch_i) begin
        st_q   <= 1'b1;
        busy_q <= 1'b1;
        ack_q  <= 1'b0;
        done_q <= 1'b0;
      end else if (busy_q) begin
        if (!ack_q && !rd_i) begin
          ack_q <= 1'b1;
          st_q  <= 1'b0;
        end
        if (done_set) begin
          done_q <= 1'b1;
          busy_q <= 1'b0;
        end
      end

      if (clr_i) begin
        res_q <= '0;
      end else if (!abort_i && done_set) begin
        res_q <= res_i;
      end
    end
  end

  assign st_o   = st_q;
  // Including the same-edge completion lets the controller advance on the
  // capture edge instead of one cycle later.
  assign done_o = done_q | done_set;
  assign res_o  = res_q;

endmodule

// File: rtl/superposition_ctrl.sv
// -----------------------------------------------------------------------------
// superposition_ctrl
// Runs NIN inner operations in parallel, captures their results into
// OUTER_ARG, then runs one outer operation and returns its result on RES.
// Toward the caller it is an ST/RD/RES responder, so instances can nest.
//
// Optional feature: define SUPERPOS_TIMEOUT_EN to add a per-phase watchdog of
// TO_CYCLES cycles; on expiry ERR is set, strobes drop, RES is zeroed and the
// run ends. Without it the block waits forever and ERR is tied 0.
//
// Ports:
//   CLK, RST             clock, synchronous active-high reset
//   ST / RD / RES        caller handshake (rising ST starts, RD=1 idle+valid)
//   INNER_ST/RD/RES      NIN inner callees (word i at [i*BW +: BW])
//   OUTER_ST/RD/RES      outer callee
//   OUTER_ARG            captured inner results feeding the outer callee
//   ERR                  watchdog error flag
// -----------------------------------------------------------------------------
module superposition_ctrl
  import superposition_pkg::*;
#(
  parameter int BW        = DEF_BW,
  parameter int NIN       = DEF_NIN,
  parameter int TO_CYCLES = DEF_TO_CYCLES
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              ST,
  output logic              RD,
  output logic [BW-1:0]     RES,
  output logic [NIN-1:0]    INNER_ST,
  input  logic [NIN-1:0]    INNER_RD,
  input  logic [NIN*BW-1:0] INNER_RES,
  output logic              OUTER_ST,
  input  logic              OUTER_RD,
  input  logic [BW-1:0]     OUTER_RES,
  output logic [NIN*BW-1:0] OUTER_ARG,
  output logic              ERR
);

  state_e         state_q, state_d;
  logic           st_old_q;
  logic           rd_q, rd_d;
  logic           start;
  logic           in_launch;
  logic           out_launch;
  logic [NIN-1:0] in_done;
  logic           out_done;
  logic           expired;

  // Only a fresh rising edge while idle starts a run; STold tracks always.
  assign start = ST & ~st_old_q & (state_q == IDLE);

`ifdef SUPERPOS_TIMEOUT_EN
  localparam int CW = $clog2(TO_CYCLES + 1);

  logic [CW-1:0] cnt_q;
  logic          err_q;
  logic          wait_st;

  assign wait_st = (state_q == I_ARM) || (state_q == I_RUN) ||
                   (state_q == O_ARM) || (state_q == O_RUN);
  assign expired = wait_st && (cnt_q == CW'(TO_CYCLES));

  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      if (state_d != state_q) begin
        cnt_q <= '0;
      end else if (wait_st) begin
        cnt_q <= cnt_q + 1'b1;
      end

      if (start) begin
        err_q <= 1'b0;
      end else if (expired) begin
        err_q <= 1'b1;
      end
    end
  end

  assign ERR = err_q;
`else
  assign expired = 1'b0;
  assign ERR     = 1'b0;
`endif

  // State and caller-side registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= IDLE;
      st_old_q <= 1'b0;
      rd_q     <= 1'b1;
    end else begin
      state_q  <= state_d;
      st_old_q <= ST;
      rd_q     <= rd_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    rd_d       = rd_q;
    in_launch  = 1'b0;
    out_launch = 1'b0;
    if (expired) begin
      state_d = DONE;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_d = I_ARM;
            rd_d    = 1'b0;
          end
        end
        I_ARM: begin
          if (&INNER_RD) begin
            in_launch = 1'b1;
            state_d   = I_RUN;
          end
        end
        I_RUN: begin
          if (&in_done) begin
            state_d = O_ARM;
          end
        end
        O_ARM: begin
          if (OUTER_RD) begin
            out_launch = 1'b1;
            state_d    = O_RUN;
          end
        end
        O_RUN: begin
          // RD rises on the same edge RES is loaded.
          if (out_done) begin
            state_d = DONE;
            rd_d    = 1'b1;
          end
        end
        DONE: begin
          // Covers the watchdog path, where RD is still low here.
          rd_d    = 1'b1;
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  for (genvar gi = 0; gi < NIN; gi++) begin : g_inner
    op_handshake_init #(.BW(BW)) u_init (
      .CLK      (CLK),
      .RST      (RST),
      .launch_i (in_launch),
      .abort_i  (expired),
      .clr_i    (1'b0),
      .rd_i     (INNER_RD[gi]),
      .res_i    (BW'(word_at(PK_W'(INNER_RES), BW, gi))),
      .st_o     (INNER_ST[gi]),
      .done_o   (in_done[gi]),
      .res_o    (OUTER_ARG[gi*BW +: BW])
    );
  end

  // The outer capture register doubles as the RES output register.
  op_handshake_init #(.BW(BW)) u_outer (
    .CLK      (CLK),
    .RST      (RST),
    .launch_i (out_launch),
    .abort_i  (expired),
    .clr_i    (expired),
    .rd_i     (OUTER_RD),
    .res_i    (OUTER_RES),
    .st_o     (OUTER_ST),
    .done_o   (out_done),
    .res_o    (RES)
  );

  assign RD = rd_q;

endmodule

// File: tb/tb_superposition_ctrl.sv
// -----------------------------------------------------------------------------
// tb_superposition_ctrl
// Directed bench for superposition_ctrl with behavioural callee stubs.
// Stub latency L: the stub accepts ST on one edge and presents RD=1 with its
// result L-1 edges later. The outer stub returns the sum of the two OUTER_ARG
// words. Timeout scenario runs only when SUPERPOS_TIMEOUT_EN is defined.
// -----------------------------------------------------------------------------
module tb_superposition_ctrl;

  localparam int BW   = 16;
  localparam int NIN  = 2;
  localparam int TO_C = 20;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              st  = 1'b0;
  logic              rd;
  logic [BW-1:0]     res;
  logic [NIN-1:0]    inner_st;
  logic [NIN-1:0]    in_rd;
  logic [NIN*BW-1:0] inner_res_bus;
  logic              outer_st;
  logic              out_rd;
  logic [BW-1:0]     out_res;
  logic [NIN*BW-1:0] outer_arg;
  logic              err;

  always #5 clk = ~clk;

  superposition_ctrl #(.BW(BW), .NIN(NIN), .TO_CYCLES(TO_C)) dut (
    .CLK       (clk),
    .RST       (rst),
    .ST        (st),
    .RD        (rd),
    .RES       (res),
    .INNER_ST  (inner_st),
    .INNER_RD  (in_rd),
    .INNER_RES (inner_res_bus),
    .OUTER_ST  (outer_st),
    .OUTER_RD  (out_rd),
    .OUTER_RES (out_res),
    .OUTER_ARG (outer_arg),
    .ERR       (err)
  );

  // ---------------- inner callee stubs ----------------
  logic [BW-1:0]  in_res [NIN];
  logic [BW-1:0]  in_val [NIN];
  int             in_lat [NIN];
  int             in_cnt [NIN];
  int             in_starts [NIN] = '{default: 0};
  logic [NIN-1:0] in_hold = '0;

  always_comb begin
    inner_res_bus = '0;
    for (int i = 0; i < NIN; i++) inner_res_bus[i*BW +: BW] = in_res[i];
  end

  always @(posedge clk) begin
    for (int i = 0; i < NIN; i++) begin
      if (rst) begin
        in_rd[i]  <= 1'b1;
        in_res[i] <= '0;
        in_cnt[i] <= 0;
      end else if (in_cnt[i] > 0) begin
        if (in_cnt[i] == 1) begin
          in_rd[i]  <= 1'b1;
          in_res[i] <= in_val[i];
        end
        in_cnt[i] <= in_cnt[i] - 1;
      end else if (in_hold[i]) begin
        in_rd[i] <= 1'b0;
      end else if (!in_rd[i]) begin
        in_rd[i] <= 1'b1;
      end else if (inner_st[i]) begin
        in_rd[i]     <= 1'b0;
        in_cnt[i]    <= in_lat[i] - 1;
        in_starts[i] <= in_starts[i] + 1;
      end
    end
  end

  // ---------------- outer callee stub ----------------
  int                out_lat    = 3;
  int                out_cnt    = 0;
  int                out_starts = 0;
  logic              out_never  = 1'b0;
  logic [NIN*BW-1:0] arg_at_start = '0;
  logic [BW-1:0]     arg_w0, arg_w1;

  assign arg_w0 = outer_arg[BW-1:0];
  assign arg_w1 = outer_arg[2*BW-1:BW];

  always @(posedge clk) begin
    if (rst) begin
      out_rd  <= 1'b1;
      out_res <= '0;
      out_cnt <= 0;
    end else if (out_cnt > 0) begin
      if (out_cnt == 1) begin
        out_rd  <= 1'b1;
        out_res <= arg_w0 + arg_w1;
      end
      out_cnt <= out_cnt - 1;
    end else if (!out_rd) begin
      if (!out_never) out_rd <= 1'b1;
    end else if (outer_st) begin
      out_rd       <= 1'b0;
      out_cnt      <= out_never ? 0 : out_lat - 1;
      out_starts   <= out_starts + 1;
      arg_at_start <= outer_arg;
    end
  end

  // ---------------- checking helpers ----------------
  int compared   = 0;
  int mismatched = 0;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Counts edges until RD is seen high; returns the number of RD-low cycles
  // assuming the first edge counted is the caller start edge.
  task automatic wait_rd(output int low);
    int n;
    n = 0;
    do begin
      tick;
      n++;
    end while (rd !== 1'b1 && n < 300);
    low = n - 1;
    chk("rd_return", 64'(rd), 64'd1);
  endtask

  task automatic start_run;
    st = 1'b0;
    tick;
    st = 1'b1;
  endtask

  task automatic set_inner(input logic [BW-1:0] v0, input logic [BW-1:0] v1,
                           input int l0, input int l1);
    in_val[0] = v0;
    in_val[1] = v1;
    in_lat[0] = l0;
    in_lat[1] = l1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    int low;
    int b0, b1, bo;

    set_inner(16'h1234, 16'h00AB, 3, 3);

    // ---- reset state ----
    rst = 1'b1;
    repeat (3) tick;
    chk("rst_rd",        64'(rd),        64'd1);
    chk("rst_res",       64'(res),       64'd0);
    chk("rst_inner_st",  64'(inner_st),  64'd0);
    chk("rst_outer_st",  64'(outer_st),  64'd0);
    chk("rst_outer_arg", 64'(outer_arg), 64'd0);
    chk("rst_err",       64'(err),       64'd0);
    rst = 1'b0;
    tick;

    // ---- 1: nominal ----
    b0 = in_starts[0]; b1 = in_starts[1]; bo = out_starts;
    start_run;
    wait_rd(low);
    $display("t1 nominal: rd_low=%0d res=%h arg=%h", low, res, outer_arg);
    chk("t1_rd_low",   64'(low),                 64'd10);
    chk("t1_res",      64'(res),                 64'h12DF);
    chk("t1_arg",      64'(outer_arg),           64'h00AB_1234);
    chk("t1_in0_once", 64'(in_starts[0] - b0),   64'd1);
    chk("t1_in1_once", 64'(in_starts[1] - b1),   64'd1);
    chk("t1_out_once", 64'(out_starts - bo),     64'd1);

    // ---- 2: skewed completion ----
    set_inner(16'h1111, 16'h0022, 9, 3);
    bo = out_starts;
    start_run;
    wait_rd(low);
    $display("t2 skewed: rd_low=%0d res=%h arg_at_outer_start=%h", low, res, arg_at_start);
    chk("t2_rd_low",       64'(low),             64'd16);
    chk("t2_res",          64'(res),             64'h1133);
    chk("t2_arg_at_start", 64'(arg_at_start),    64'h0022_1111);
    chk("t2_out_once",     64'(out_starts - bo), 64'd1);

    // ---- 3: busy inner callee at start ----
    set_inner(16'h0100, 16'h0200, 3, 3);
    b0 = in_starts[0]; b1 = in_starts[1]; bo = out_starts;
    in_hold[1] = 1'b1;
    st = 1'b0;
    tick;
    st = 1'b1;
    repeat (6) tick;
    chk("t3_inner_st_held", 64'(inner_st),          64'd0);
    chk("t3_rd_busy",       64'(rd),                64'd0);
    chk("t3_no_start",      64'(in_starts[0] - b0), 64'd0);
    in_hold[1] = 1'b0;
    wait_rd(low);
    $display("t3 busy: tail=%0d res=%h", low, res);
    chk("t3_tail",     64'(low),               64'd10);
    chk("t3_res",      64'(res),               64'h0300);
    chk("t3_in0_once", 64'(in_starts[0] - b0), 64'd1);
    chk("t3_in1_once", 64'(in_starts[1] - b1), 64'd1);
    chk("t3_out_once", 64'(out_starts - bo),   64'd1);

    // ---- 4: caller handshake ----
    st = 1'b0;
    tick;
    bo = out_starts;
    st = 1'b1;
    wait_rd(low);
    $display("t4 held ST: rd_low=%0d res=%h", low, res);
    chk("t4_rd_low", 64'(low), 64'd10);
    repeat (12) tick;
    chk("t4_no_rerun", 64'(out_starts - bo), 64'd1);
    chk("t4_rd_idle",  64'(rd),              64'd1);
    st = 1'b0;
    tick;
    st = 1'b1;
    tick;
    chk("t4_restart", 64'(rd), 64'd0);
    repeat (3) tick;
    st = 1'b0;
    tick;
    st = 1'b1;
    wait_rd(low);
    $display("t4 re-edge mid-run: remaining=%0d", low);
    chk("t4_mid_low", 64'(low), 64'd5);
    repeat (15) tick;
    chk("t4_two_runs", 64'(out_starts - bo), 64'd2);
    chk("t4_rd_end",   64'(rd),              64'd1);
    st = 1'b0;
    tick;

    // ---- 5: reset mid-run ----
    set_inner(16'h0A0A, 16'h0505, 9, 9);
    start_run;
    repeat (2) tick;
    chk("t5_launched", 64'(inner_st), 64'd3);
    rst = 1'b1;
    st  = 1'b0;
    tick;
    $display("t5 reset: rd=%0d res=%h inner_st=%b arg=%h", rd, res, inner_st, outer_arg);
    chk("t5_rd",        64'(rd),        64'd1);
    chk("t5_res",       64'(res),       64'd0);
    chk("t5_inner_st",  64'(inner_st),  64'd0);
    chk("t5_outer_st",  64'(outer_st),  64'd0);
    chk("t5_outer_arg", 64'(outer_arg), 64'd0);
    rst = 1'b0;
    tick;
    set_inner(16'h0A0A, 16'h0505, 3, 3);
    start_run;
    wait_rd(low);
    $display("t5 after reset: rd_low=%0d res=%h", low, res);
    chk("t5_rd_low", 64'(low),       64'd10);
    chk("t5_res2",   64'(res),       64'h0F0F);
    chk("t5_arg2",   64'(outer_arg), 64'h0505_0A0A);

`ifdef SUPERPOS_TIMEOUT_EN
    // ---- 6: watchdog on a stuck outer callee ----
    set_inner(16'h0001, 16'h0002, 3, 3);
    out_never = 1'b1;
    start_run;
    wait_rd(low);
    $display("t6 timeout: rd_low=%0d err=%0d res=%h", low, err, res);
    chk("t6_rd_low",   64'(low),      64'd28);
    chk("t6_err",      64'(err),      64'd1);
    chk("t6_res",      64'(res),      64'd0);
    chk("t6_outer_st", 64'(outer_st), 64'd0);
    out_never = 1'b0;
    tick;
    start_run;
    tick;
    chk("t6_err_clear", 64'(err), 64'd0);
    wait_rd(low);
    $display("t6 recovery: remaining=%0d res=%h", low, res);
    chk("t6_rec_low", 64'(low), 64'd9);
    chk("t6_rec_res", 64'(res), 64'h0003);
`endif

    st = 1'b0;
    tick;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
